adap_quan_sched: RTL and testbench
==================================

ADAP_QUAN_SCHED -- requirements
Module: adap_quan_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of channels sharing one adaptive quantizer; legal values 2, 4, 8.
REQ-002 SHALL have the following ports, with CW = log2(NCH):
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NCH  per-channel request; held with operands until granted.
- D_IN  in  16*NCH  per-channel difference signal; channel k at bits [16k+15:16k].
- Y_IN  in  13*NCH  per-channel quantizer scale factor; channel k at bits [13k+12:13k].
- RATE_IN  in  2*NCH  per-channel rate code; channel k at bits [2k+1:2k].
- GNT  out  NCH  one-hot, one-cycle grant pulse.
- Q_D  out  16  registered D operand to the adaptive quantizer.
- Q_Y  out  13  registered Y operand to the adaptive quantizer.
- Q_RATE  out  2  registered RATE operand to the adaptive quantizer.
- Q_I  in  5  combinational codeword returned by the adaptive quantizer.
- I_OUT  out  5  captured codeword.
- I_CH  out  CW  channel index of I_OUT.
- I_VLD  out  1  result valid.
- I_RDY  in  1  consumer ready.
- BUSY  out  1  scheduler not idle.
- CNT  out  16  completed-result counter.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, EVAL, DONE.
REQ-004 Arbitration SHALL occur only in IDLE, and in DONE when I_RDY=1.
- Round-robin search order: PTR, PTR+1, ... mod NCH.
- The first asserted REQ wins.
REQ-005 On a win by channel k, at the next edge the block SHALL:
- load Q_D, Q_Y, Q_RATE from channel k's slices;
- set GNT[k]=1 for exactly one cycle;
- set PTR=(k+1) mod NCH;
- enter EVAL.
REQ-006 In EVAL the block SHALL NOT arbitrate; at the next edge it SHALL capture I_OUT<=Q_I, I_CH<=k, I_VLD<=1, and enter DONE.
REQ-007 In DONE with I_RDY=0, I_OUT, I_CH, I_VLD=1, and Q_* SHALL hold stable, with no GNT, until I_RDY=1.
REQ-008 In DONE with I_RDY=1, the result completes at the next edge:
- CNT increments by 1;
- if any REQ is asserted, a new grant per REQ-005 occurs at the same edge and the state goes to EVAL with I_VLD<=0;
- otherwise the state goes to IDLE with I_VLD<=0.
REQ-009 Latency SHALL be two edges from the REQ-sampling edge to I_VLD=1; peak throughput SHALL be one result per 2 cycles.
REQ-010 Requester protocol: a requester SHALL deassert REQ, or present a new sample, at the edge after GNT; a REQ seen in IDLE or DONE is always treated as a new request.
REQ-011 GNT SHALL be zero in all cycles except the single cycle following a grant edge; at most one bit is ever set.
REQ-012 Q_D, Q_Y, Q_RATE SHALL change only on grant edges; they hold their last values otherwise.
REQ-013 CNT SHALL be 16-bit unsigned and wrap 65535 -> 0; it increments only on an edge where I_VLD=1 and I_RDY=1.
REQ-014 BUSY SHALL be registered and equal 1 whenever the state is not IDLE.
REQ-015 I_RDY SHALL be ignored when I_VLD=0.
REQ-016 REQ asserted simultaneously on all channels SHALL be served in strict rotation, with no channel starved for more than NCH-1 grants.

Reset
REQ-017 RESET=1 at an edge SHALL, regardless of state, set:
- state=IDLE, PTR=0, CNT=0;
- GNT=0, Q_D=0, Q_Y=0, Q_RATE=0;
- I_OUT=0, I_CH=0, I_VLD=0, BUSY=0.
REQ-018 A result in flight (EVAL or DONE) at reset SHALL be discarded: no completion and no CNT increment.
REQ-019 REQ sampled during a reset cycle SHALL NOT be granted; arbitration resumes on the first edge after RESET falls.

Verification
REQ-020 Reset: assert RESET 2 cycles with random inputs -> all outputs 0; no GNT for the cycle after RESET falls if REQ=0.
REQ-021 Single request, NCH=4: REQ=4'b0100, D_IN slice 2 = 16'h0100, Y_IN slice 2 = 13'h0200, RATE_IN slice 2 = 2'b00, I_RDY=1.
- Next cycle: GNT=4'b0100, Q_D=16'h0100, Q_Y=13'h0200.
- Following cycle: I_VLD=1, I_CH=2, I_OUT equals the quantizer model's output.
- Then CNT=1.
REQ-022 Full contention: REQ=4'b1111 held, I_RDY=1 -> GNT order 0,1,2,3,0 at 2-cycle spacing; I_CH follows one cycle later; CNT=5 after 5 results.
REQ-023 Backpressure: I_RDY=0 for 5 cycles while in DONE with REQ=4'b0011.
- I_OUT, I_CH, I_VLD=1 stable; GNT=0; BUSY=1; CNT unchanged.
- Then I_RDY=1: CNT+1 and the next grant goes to the next channel from PTR at the same edge.
REQ-024 Reset mid-operation: RESET during EVAL -> next cycle I_VLD=0, GNT=0, CNT unchanged at 0 (the previous count is cleared); the next REQ=4'b1000 is granted channel 3 after channels 0-2 are checked from PTR=0.
REQ-025 Counter wrap: 65536 completions -> CNT=0, and no glitch on I_VLD.

Source files
------------

// File: rtl/adap_quan_sched.sv
// Round-robin scheduler that time-shares one adaptive quantizer among NCH channels.
// Each grant registers one channel's operands, captures the codeword a cycle later and holds it until consumed.
module adap_quan_sched #(
  parameter int unsigned NCH = 4,
  localparam int unsigned CW = $clog2(NCH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    REQ,
  input  logic [16*NCH-1:0] D_IN,
  input  logic [13*NCH-1:0] Y_IN,
  input  logic [2*NCH-1:0]  RATE_IN,
  output logic [NCH-1:0]    GNT,
  output logic [15:0]       Q_D,
  output logic [12:0]       Q_Y,
  output logic [1:0]        Q_RATE,
  input  logic [4:0]        Q_I,
  output logic [4:0]        I_OUT,
  output logic [CW-1:0]     I_CH,
  output logic              I_VLD,
  input  logic              I_RDY,
  output logic              BUSY,
  output logic [15:0]       CNT
);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   ptr_q;
  logic [CW-1:0]   ch_q;
  logic [NCH-1:0]  gnt_q;
  logic [15:0]     qd_q;
  logic [12:0]     qy_q;
  logic [1:0]      qrate_q;
  logic [4:0]      iout_q;
  logic [CW-1:0]   ich_q;
  logic            vld_q;
  logic            busy_q;
  logic [15:0]     cnt_q;

  logic            win_found;
  logic [CW-1:0]   win_ch;
  logic [CW-1:0]   idx;
  logic            grant;
  logic            capture;
  logic            complete;

  // Round-robin search starting at ptr_q; index wraps naturally since NCH is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr_q + i[CW-1:0];
      if (!win_found && REQ[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (win_found) state_d = StEval;
      StEval: state_d = StDone;
      StDone: begin
        if (I_RDY) state_d = win_found ? StEval : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant    = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: grant = win_found;
      StEval: capture = 1'b1;
      StDone: begin
        complete = I_RDY;
        grant    = I_RDY && win_found;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q   <= '0;
      ch_q    <= '0;
      gnt_q   <= '0;
      qd_q    <= '0;
      qy_q    <= '0;
      qrate_q <= '0;
      iout_q  <= '0;
      ich_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      gnt_q  <= grant ? (NCH'(1) << win_ch) : '0;
      busy_q <= (state_d != StIdle);
      if (grant) begin
        qd_q    <= D_IN[16*win_ch +: 16];
        qy_q    <= Y_IN[13*win_ch +: 13];
        qrate_q <= RATE_IN[2*win_ch +: 2];
        ch_q    <= win_ch;
        ptr_q   <= win_ch + CW'(1);
      end
      if (capture) begin
        iout_q <= Q_I;
        ich_q  <= ch_q;
        vld_q  <= 1'b1;
      end
      if (complete) begin
        vld_q <= 1'b0;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign GNT    = gnt_q;
  assign Q_D    = qd_q;
  assign Q_Y    = qy_q;
  assign Q_RATE = qrate_q;
  assign I_OUT  = iout_q;
  assign I_CH   = ich_q;
  assign I_VLD  = vld_q;
  assign BUSY   = busy_q;
  assign CNT    = cnt_q;

endmodule

// File: tb/tb_adap_quan_sched.sv
// Directed bench for adap_quan_sched: vector table for full contention plus hand sequences
// for reset, single request, backpressure and sustained throughput.
module tb_adap_quan_sched;

  localparam int unsigned NCH = 4;

  logic        CLK;
  logic        RESET;
  logic [3:0]  REQ;
  logic [63:0] D_IN;
  logic [51:0] Y_IN;
  logic [7:0]  RATE_IN;
  logic [3:0]  GNT;
  logic [15:0] Q_D;
  logic [12:0] Q_Y;
  logic [1:0]  Q_RATE;
  logic [4:0]  Q_I;
  logic [4:0]  I_OUT;
  logic [1:0]  I_CH;
  logic        I_VLD;
  logic        I_RDY;
  logic        BUSY;
  logic [15:0] CNT;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] d_ch[4];
  logic [12:0] y_ch[4];
  logic [1:0]  r_ch[4];

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic        vld;
    logic [1:0]  ich;
    int          qch;
    logic [15:0] cnt;
    logic        busy;
  } vec_t;

  vec_t vt[11];

  adap_quan_sched #(.NCH(NCH)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .REQ    (REQ),
    .D_IN   (D_IN),
    .Y_IN   (Y_IN),
    .RATE_IN(RATE_IN),
    .GNT    (GNT),
    .Q_D    (Q_D),
    .Q_Y    (Q_Y),
    .Q_RATE (Q_RATE),
    .Q_I    (Q_I),
    .I_OUT  (I_OUT),
    .I_CH   (I_CH),
    .I_VLD  (I_VLD),
    .I_RDY  (I_RDY),
    .BUSY   (BUSY),
    .CNT    (CNT)
  );

  // Stand-in quantizer: any fixed combinational function of the operands will do.
  function automatic logic [4:0] qmodel(input logic [15:0] d, input logic [12:0] y,
                                        input logic [1:0] r);
    return (d[12:8] ^ y[9:5]) + {3'b000, r};
  endfunction

  assign Q_I = qmodel(Q_D, Q_Y, Q_RATE);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_data();
    for (int k = 0; k < 4; k++) begin
      D_IN[16*k +: 16]  = d_ch[k];
      Y_IN[13*k +: 13]  = y_ch[k];
      RATE_IN[2*k +: 2] = r_ch[k];
    end
  endtask

  initial begin
    d_ch[0] = 16'h0A00; d_ch[1] = 16'h1300; d_ch[2] = 16'h0100; d_ch[3] = 16'h1C00;
    y_ch[0] = 13'h0040; y_ch[1] = 13'h0160; y_ch[2] = 13'h0200; y_ch[3] = 13'h03E0;
    r_ch[0] = 2'd1;     r_ch[1] = 2'd2;     r_ch[2] = 2'd0;     r_ch[3] = 2'd3;

    //           req    rdy   gnt   vld   ich   qch cnt    busy
    vt[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 0, 16'd0, 1'b1};
    vt[1]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 0, 16'd0, 1'b1};
    vt[2]  = '{4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1, 16'd1, 1'b1};
    vt[3]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1, 16'd1, 1'b1};
    vt[4]  = '{4'hF, 1'b1, 4'h4, 1'b0, 2'd1, 2, 16'd2, 1'b1};
    vt[5]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 2, 16'd2, 1'b1};
    vt[6]  = '{4'hF, 1'b1, 4'h8, 1'b0, 2'd2, 3, 16'd3, 1'b1};
    vt[7]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 3, 16'd3, 1'b1};
    vt[8]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd3, 0, 16'd4, 1'b1};
    vt[9]  = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 0, 16'd4, 1'b1};
    vt[10] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 0, 16'd5, 1'b0};

    // Reset with random inputs.
    RESET   = 1'b1;
    REQ     = 4'($urandom());
    D_IN    = {$urandom(), $urandom()};
    Y_IN    = 52'({$urandom(), $urandom()});
    RATE_IN = 8'($urandom());
    I_RDY   = 1'($urandom());
    step();
    REQ = 4'($urandom());
    step();
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_qd", 32'(Q_D), 32'h0);
    chk("rst_qy", 32'(Q_Y), 32'h0);
    chk("rst_qrate", 32'(Q_RATE), 32'h0);
    chk("rst_iout", 32'(I_OUT), 32'h0);
    chk("rst_ich", 32'(I_CH), 32'h0);
    chk("rst_vld", 32'(I_VLD), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_cnt", 32'(CNT), 32'h0);
    RESET = 1'b0;
    REQ   = 4'h0;
    I_RDY = 1'b0;
    load_data();
    step();
    chk("post_rst_gnt", 32'(GNT), 32'h0);
    chk("post_rst_busy", 32'(BUSY), 32'h0);

    // Full contention from PTR=0.
    for (int i = 0; i < 11; i++) begin
      REQ   = vt[i].req;
      I_RDY = vt[i].rdy;
      step();
      chk($sformatf("rr%0d_gnt", i), 32'(GNT), 32'(vt[i].gnt));
      chk($sformatf("rr%0d_vld", i), 32'(I_VLD), 32'(vt[i].vld));
      chk($sformatf("rr%0d_ich", i), 32'(I_CH), 32'(vt[i].ich));
      chk($sformatf("rr%0d_cnt", i), 32'(CNT), 32'(vt[i].cnt));
      chk($sformatf("rr%0d_busy", i), 32'(BUSY), 32'(vt[i].busy));
      chk($sformatf("rr%0d_qd", i), 32'(Q_D), 32'(d_ch[vt[i].qch]));
      if (vt[i].vld)
        chk($sformatf("rr%0d_iout", i), 32'(I_OUT),
            32'(qmodel(d_ch[vt[i].ich], y_ch[vt[i].ich], r_ch[vt[i].ich])));
    end

    // Backpressure: PTR=1, REQ=0011, consumer stalls 5 cycles in DONE.
    REQ   = 4'b0011;
    I_RDY = 1'b0;
    step();
    chk("bp_gnt", 32'(GNT), 32'h2);
    chk("bp_qd", 32'(Q_D), 32'(d_ch[1]));
    step();
    chk("bp_vld", 32'(I_VLD), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d_vld", i), 32'(I_VLD), 32'h1);
      chk($sformatf("bp%0d_ich", i), 32'(I_CH), 32'h1);
      chk($sformatf("bp%0d_iout", i), 32'(I_OUT), 32'(qmodel(d_ch[1], y_ch[1], r_ch[1])));
      chk($sformatf("bp%0d_gnt", i), 32'(GNT), 32'h0);
      chk($sformatf("bp%0d_busy", i), 32'(BUSY), 32'h1);
      chk($sformatf("bp%0d_cnt", i), 32'(CNT), 32'd5);
      chk($sformatf("bp%0d_qd", i), 32'(Q_D), 32'(d_ch[1]));
    end
    I_RDY = 1'b1;
    step();
    chk("bp_rel_cnt", 32'(CNT), 32'd6);
    chk("bp_rel_gnt", 32'(GNT), 32'h1);
    chk("bp_rel_vld", 32'(I_VLD), 32'h0);
    chk("bp_rel_qd", 32'(Q_D), 32'(d_ch[0]));
    REQ = 4'h0;
    step();
    chk("bp_next_ich", 32'(I_CH), 32'h0);
    step();
    chk("bp_end_cnt", 32'(CNT), 32'd7);
    chk("bp_end_busy", 32'(BUSY), 32'h0);

    // Single request on channel 2 (D=0100, Y=0200, RATE=0 -> codeword 17).
    REQ = 4'b0100;
    step();
    chk("single_gnt", 32'(GNT), 32'h4);
    chk("single_qd", 32'(Q_D), 32'h0100);
    chk("single_qy", 32'(Q_Y), 32'h0200);
    chk("single_qrate", 32'(Q_RATE), 32'h0);
    REQ = 4'h0;
    step();
    chk("single_vld", 32'(I_VLD), 32'h1);
    chk("single_ich", 32'(I_CH), 32'h2);
    chk("single_iout", 32'(I_OUT), 32'd17);
    step();
    chk("single_cnt", 32'(CNT), 32'd8);
    chk("single_vld_clr", 32'(I_VLD), 32'h0);

    // Reset during EVAL; PTR was 3, so a post-reset REQ=1010 must pick channel 1.
    REQ = 4'b0100;
    step();
    chk("mid_gnt", 32'(GNT), 32'h4);
    RESET = 1'b1;
    REQ   = 4'b1010;
    step();
    chk("mid_rst_vld", 32'(I_VLD), 32'h0);
    chk("mid_rst_gnt", 32'(GNT), 32'h0);
    chk("mid_rst_cnt", 32'(CNT), 32'h0);
    chk("mid_rst_busy", 32'(BUSY), 32'h0);
    RESET = 1'b0;
    step();
    chk("mid_ptr0_gnt", 32'(GNT), 32'h2);
    REQ = 4'h0;
    step();
    chk("mid_ich", 32'(I_CH), 32'h1);
    step();
    chk("mid_cnt", 32'(CNT), 32'd1);
    REQ = 4'b1000;
    step();
    chk("mid_ch3_gnt", 32'(GNT), 32'h8);
    chk("mid_ch3_qd", 32'(Q_D), 32'(d_ch[3]));
    REQ = 4'h0;
    step();
    step();
    chk("mid_ch3_cnt", 32'(CNT), 32'd2);

    // Sustained throughput: one result per two cycles, no spurious I_VLD.
    REQ = 4'b1111;
    for (int e = 1; e <= 200; e++) begin
      step();
      chk($sformatf("tp%0d_vld", e), 32'(I_VLD), 32'((e % 2) == 0));
      chk($sformatf("tp%0d_cnt", e), 32'(CNT), 32'(2 + (e - 1) / 2));
      chk($sformatf("tp%0d_gnt1h", e), 32'($onehot0(GNT)), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
